line_mem_bridge: RTL
====================

Name: line_mem_bridge

Overview:
Memory-side stage directly downstream of the 4-way/4-word cache. It accepts 128-bit cache-line read (fill) and write (writeback) requests on the cache's memory port and serialises each one into four 32-bit word accesses to the simple word-wide backing RAM. For reads it reassembles the line and returns it with a one-cycle valid pulse, and it holds waitrequest while a transaction is in flight.

Parameters:
LINE_ADDR_W, 26, width of the cache line address (i_c_addr)
WORD_W, 32, RAM word width
WORDS, 4, words per line; fixed at 4 (2-bit word index)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
i_c_addr  in  26  line address from cache (o_m_addr)
i_c_byte_en  in  4  per-word write enable; bit k enables word k
i_c_writedata  in  128  line data; word k = bits [32k+31:32k]
i_c_read  in  1  line read request
i_c_write  in  1  line write request
o_c_readdata  out  128  assembled line
o_c_readdata_valid  out  1  one-cycle pulse, line data valid
o_c_waitrequest  out  1  bridge busy; new requests are not accepted
o_r_addr  out  28  RAM word address = {line addr, word idx}
o_r_writedata  out  32  RAM write word
o_r_we  out  1  RAM write strobe, one cycle per word
o_r_re  out  1  RAM read strobe, one cycle per word
i_r_readdata  in  32  RAM read word
i_r_readdata_valid  in  1  RAM read word valid; at least 1 cycle after o_r_re
o_err  out  1  sticky: read and write requested together
cnt_line_rd  out  32  completed line reads
cnt_line_wr  out  32  completed line writes

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE. All outputs 0, including o_c_readdata, counters and o_err. Word index 0.
- o_c_waitrequest = (state != IDLE), driven from a register.
- All RAM-side outputs are registered.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, RESP.
- IDLE: a request is accepted on a posedge where i_c_write or i_c_read is 1. At that edge the bridge latches addr, byte_en and writedata, and clears the word index k.
  - Write accept -> WR.
  - Read accept -> RD_ISSUE.
  - Both high -> the write is executed, the read is dropped, and o_err is set (it stays set until rst).
- WR: one cycle per word, k = 0..3 ascending.
  - If byte_en[k]=1: o_r_we=1, o_r_addr={addr,k}, o_r_writedata=word k.
  - If byte_en[k]=0: o_r_we=0 for that cycle. The slot is still consumed, so latency is fixed.
  - After k=3 -> IDLE and cnt_line_wr increments.
  - Write latency: waitrequest is high exactly 4 cycles after the accept edge, including when byte_en=0.
- RD_ISSUE: o_r_re=1 for one cycle, o_r_addr={addr,k} -> RD_WAIT.
- RD_WAIT: hold until i_r_readdata_valid=1, then capture i_r_readdata into lane k of o_c_readdata.
  - k<3 -> k+1, RD_ISSUE.
  - k=3 -> RESP.
- RESP: o_c_readdata_valid=1 for exactly one cycle; o_c_readdata holds the line until the next read completes -> IDLE; cnt_line_rd increments.
- Read latency with RAM latency L: 4*(1+L)+1 cycles of waitrequest high after the accept edge.
- i_c_byte_en is ignored for reads; all four words are always fetched.
- i_r_readdata_valid outside RD_WAIT is ignored and creates no lane write.
- Requests presented while waitrequest=1 are ignored. The cache must hold or re-present them.
- Counters wrap 0xFFFFFFFF -> 0.
- Reset mid-transaction: return to IDLE next edge; outputs are cleared. Words already written stay written (no rollback). A pending RAM response arriving after reset is ignored.

Test Plan:
- Full write: addr=0x0000005, byte_en=0xF, data=0x00000004_00000003_00000002_00000001.
  - Required: o_r_we on 4 consecutive cycles at o_r_addr 0x14..0x17 with data 1,2,3,4.
  - Required: waitrequest high 4 cycles; cnt_line_wr=1.
- Partial write: byte_en=0x5.
  - Required: o_r_we only for words 0 and 2; still 4 busy cycles.
  - Required: byte_en=0x0 -> no o_r_we, 4 busy cycles, cnt_line_wr increments.
- Read after write with L=1: read addr 0x0000005.
  - Required: o_r_re at 0x14,0x15,0x16,0x17 and waitrequest high 9 cycles.
  - Required: readdata_valid pulses once with 0x00000004_00000003_00000002_00000001.
- Variable RAM latency (L=1,3,0-stall mix) plus a stray i_r_readdata_valid while in IDLE.
  - Required: correct line assembled and no lane corruption.
- Simultaneous i_c_read=i_c_write=1.
  - Required: write executed, no o_r_re, o_err=1 and sticky, no readdata_valid.
- rst asserted during RD_WAIT of word 2.
  - Required: next cycle IDLE, waitrequest=0, readdata=0, counters=0; a late RAM valid is ignored; a subsequent read completes normally.

Source files
------------

// File: rtl/line_mem_bridge_if.sv
// Bus bundle between the cache memory port, the line bridge and the word-wide backing RAM.
// The slave modport is the bridge; the master modport is the cache plus the RAM around it.
interface line_mem_bridge_if #(
   parameter int unsigned LINE_ADDR_W = 26,
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned WORDS       = 4
);
   localparam int unsigned LineW = WORD_W * WORDS;

   logic [LINE_ADDR_W-1:0] i_c_addr;
   logic [WORDS-1:0]       i_c_byte_en;
   logic [LineW-1:0]       i_c_writedata;
   logic                   i_c_read;
   logic                   i_c_write;
   logic [LineW-1:0]       o_c_readdata;
   logic                   o_c_readdata_valid;
   logic                   o_c_waitrequest;
   logic [LINE_ADDR_W+1:0] o_r_addr;
   logic [WORD_W-1:0]      o_r_writedata;
   logic                   o_r_we;
   logic                   o_r_re;
   logic [WORD_W-1:0]      i_r_readdata;
   logic                   i_r_readdata_valid;

   modport slave (
      input  i_c_addr, i_c_byte_en, i_c_writedata, i_c_read, i_c_write,
      input  i_r_readdata, i_r_readdata_valid,
      output o_c_readdata, o_c_readdata_valid, o_c_waitrequest,
      output o_r_addr, o_r_writedata, o_r_we, o_r_re
   );

   modport master (
      output i_c_addr, i_c_byte_en, i_c_writedata, i_c_read, i_c_write,
      output i_r_readdata, i_r_readdata_valid,
      input  o_c_readdata, o_c_readdata_valid, o_c_waitrequest,
      input  o_r_addr, o_r_writedata, o_r_we, o_r_re
   );
endinterface

// File: rtl/line_mem_bridge.sv
// Serialises 128-bit cache line reads/writes into four 32-bit RAM word accesses and
// reassembles read lines; every output is a register.
module line_mem_bridge #(
   parameter int unsigned LINE_ADDR_W = 26,
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned WORDS       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   line_mem_bridge_if.slave       bus,
   output logic                   o_err,
   output logic [31:0]            cnt_line_rd,
   output logic [31:0]            cnt_line_wr
);
   localparam int unsigned LineW = WORD_W * WORDS;

   typedef enum logic [2:0] {StIdle, StWr, StRdIssue, StRdWait, StResp} state_e;

   state_e                 state_q;
   logic [LINE_ADDR_W-1:0] addr_q;
   logic [WORDS-1:0]       be_q;
   logic [LineW-1:0]       wdata_q;
   logic [1:0]             idx_q;
   logic [1:0]             idx_nxt;

   assign idx_nxt = idx_q + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q                <= StIdle;
         addr_q                 <= '0;
         be_q                   <= '0;
         wdata_q                <= '0;
         idx_q                  <= 2'd0;
         bus.o_c_readdata       <= '0;
         bus.o_c_readdata_valid <= 1'b0;
         bus.o_c_waitrequest    <= 1'b0;
         bus.o_r_addr           <= '0;
         bus.o_r_writedata      <= '0;
         bus.o_r_we             <= 1'b0;
         bus.o_r_re             <= 1'b0;
         o_err                  <= 1'b0;
         cnt_line_rd            <= '0;
         cnt_line_wr            <= '0;
      end else begin
         bus.o_r_we             <= 1'b0;
         bus.o_r_re             <= 1'b0;
         bus.o_c_readdata_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.i_c_write || bus.i_c_read) begin
                  addr_q              <= bus.i_c_addr;
                  be_q                <= bus.i_c_byte_en;
                  wdata_q             <= bus.i_c_writedata;
                  idx_q               <= 2'd0;
                  bus.o_c_waitrequest <= 1'b1;
                  bus.o_r_addr        <= {bus.i_c_addr, 2'd0};
                  // Word 0 is launched on the accept edge so each slot is one busy cycle.
                  if (bus.i_c_write) begin
                     state_q           <= StWr;
                     bus.o_r_we        <= bus.i_c_byte_en[0];
                     bus.o_r_writedata <= bus.i_c_writedata[WORD_W-1:0];
                     if (bus.i_c_read) o_err <= 1'b1;
                  end else begin
                     state_q    <= StRdIssue;
                     bus.o_r_re <= 1'b1;
                  end
               end
            end
            StWr: begin
               if (idx_q == 2'd3) begin
                  state_q             <= StIdle;
                  bus.o_c_waitrequest <= 1'b0;
                  cnt_line_wr         <= cnt_line_wr + 32'd1;
               end else begin
                  idx_q             <= idx_nxt;
                  bus.o_r_addr      <= {addr_q, idx_nxt};
                  bus.o_r_we        <= be_q[idx_nxt];
                  bus.o_r_writedata <= wdata_q[idx_nxt*WORD_W +: WORD_W];
               end
            end
            StRdIssue: begin
               state_q <= StRdWait;
            end
            StRdWait: begin
               if (bus.i_r_readdata_valid) begin
                  bus.o_c_readdata[idx_q*WORD_W +: WORD_W] <= bus.i_r_readdata;
                  if (idx_q == 2'd3) begin
                     state_q                <= StResp;
                     bus.o_c_readdata_valid <= 1'b1;
                  end else begin
                     idx_q        <= idx_nxt;
                     state_q      <= StRdIssue;
                     bus.o_r_re   <= 1'b1;
                     bus.o_r_addr <= {addr_q, idx_nxt};
                  end
               end
            end
            StResp: begin
               state_q             <= StIdle;
               bus.o_c_waitrequest <= 1'b0;
               cnt_line_rd         <= cnt_line_rd + 32'd1;
            end
            default: begin
               state_q             <= StIdle;
               bus.o_c_waitrequest <= 1'b0;
            end
         endcase
      end
   end

endmodule
